// File: rtl/register_file_write_arbiter_if.sv
// Bus bundle between two write requesters, the arbiter, and the register-file write port.
// The master side owns the request fields; the slave side (the arbiter) owns readies and the write port.
interface register_file_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              rf_enable;
  logic [ADDR_W-1:0] rf_rw;
  logic [DATA_W-1:0] rf_pw;
  logic              busy;
  logic [15:0]       write_count;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_enable, rf_rw, rf_pw, busy, write_count
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_enable, rf_rw, rf_pw, busy, write_count
  );
endinterface

// File: rtl/register_file_write_arbiter.sv
// Two-requester write arbiter for a single register-file write port.
// Each requester owns a one-entry holding buffer; ties alternate with last_grant.
module register_file_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic clock,
  input logic reset,
  register_file_write_arbiter_if.slave bus
);

  logic [1:0]        buf_valid;
  logic [ADDR_W-1:0] buf_addr [2];
  logic [DATA_W-1:0] buf_data [2];
  logic              last_grant;

  logic              grant_any;
  logic              grant_idx;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic [1:0]        accept;

  logic              rf_enable_q;
  logic [ADDR_W-1:0] rf_rw_q;
  logic [DATA_W-1:0] rf_pw_q;
  logic [15:0]       write_count_q;

  // Grant depends only on held state, so no valid-to-ready combinational path exists.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    grant_any = 1'b0;
    grant_idx = 1'b0;
    case (buf_valid)
      2'b01: begin grant_any = 1'b1; grant_idx = 1'b0;        end
      2'b10: begin grant_any = 1'b1; grant_idx = 1'b1;        end
      2'b11: begin grant_any = 1'b1; grant_idx = ~last_grant; end
      default: ;
    endcase
    grant = grant_any ? (2'b01 << grant_idx) : 2'b00;
  end

  assign ready[0]  = ~reset & (~buf_valid[0] | grant[0]);
  assign ready[1]  = ~reset & (~buf_valid[1] | grant[1]);
  assign accept[0] = bus.req0_valid & ready[0];
  assign accept[1] = bus.req1_valid & ready[1];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid     <= 2'b00;
      rf_enable_q   <= 1'b0;
      rf_rw_q       <= '0;
      rf_pw_q       <= '0;
      write_count_q <= '0;
      last_grant    <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept[i])     buf_valid[i] <= 1'b1;
        else if (grant[i]) buf_valid[i] <= 1'b0;
      end
      if (grant_any) begin
        rf_enable_q   <= 1'b1;
        rf_rw_q       <= buf_addr[grant_idx];
        rf_pw_q       <= buf_data[grant_idx];
        write_count_q <= write_count_q + 16'd1;
        last_grant    <= grant_idx;
      end else begin
        rf_enable_q   <= 1'b0;
      end
    end
  end

  // NOTE: buffer payloads are left out of reset; the valid bits alone decide whether they are used.
  always_ff @(posedge clock) begin
    if (accept[0]) begin
      buf_addr[0] <= bus.req0_addr;
      buf_data[0] <= bus.req0_data;
    end
    if (accept[1]) begin
      buf_addr[1] <= bus.req1_addr;
      buf_data[1] <= bus.req1_data;
    end
  end

  assign bus.req0_ready  = ready[0];
  assign bus.req1_ready  = ready[1];
  assign bus.rf_enable   = rf_enable_q;
  assign bus.rf_rw       = rf_rw_q;
  assign bus.rf_pw       = rf_pw_q;
  assign bus.write_count = write_count_q;
  assign bus.busy        = (|buf_valid) | rf_enable_q;

endmodule

// File: tb/tb_register_file_write_arbiter.sv
// Directed bench for register_file_write_arbiter: reset, single, tie, streaming, reset mid-flight, wrap.
// Inputs change 1 ns after a rising edge; register-file writes are logged on the falling edge.
module tb_register_file_write_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  register_file_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  register_file_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [ADDR_W+DATA_W-1:0] obs_q [$];

  always @(negedge clock) begin
    if (bus.rf_enable === 1'b1) obs_q.push_back({bus.rf_rw, bus.rf_pw});
  end

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    obs_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready0: got %b want 0", bus.req0_ready); end
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready1: got %b want 0", bus.req1_ready); end
    step();
    n_cmp++; if (bus.rf_enable !== 1'b0) begin n_err++; $display("FAIL reset_rf_enable: got %b want 0", bus.rf_enable); end
    n_cmp++; if (bus.rf_rw !== 5'd0) begin n_err++; $display("FAIL reset_rf_rw: got %h want 0", bus.rf_rw); end
    n_cmp++; if (bus.rf_pw !== 32'd0) begin n_err++; $display("FAIL reset_rf_pw: got %h want 0", bus.rf_pw); end
    n_cmp++; if (bus.write_count !== 16'd0) begin n_err++; $display("FAIL reset_write_count: got %0d want 0", bus.write_count); end
    idle_inputs();
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready0: got %b want 1", bus.req0_ready); end
    n_cmp++; if (bus.req1_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready1: got %b want 1", bus.req1_ready); end
    obs_q.delete();
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h14;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready0: got %b want 1", bus.req0_ready); end
    step();
    bus.req0_valid = 1'b0;
    n_cmp++; if (bus.rf_enable !== 1'b0) begin n_err++; $display("FAIL single_early_enable: got %b want 0", bus.rf_enable); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    step();
    n_cmp++; if (bus.rf_enable !== 1'b1) begin n_err++; $display("FAIL single_enable: got %b want 1", bus.rf_enable); end
    n_cmp++; if (bus.rf_rw !== 5'd5) begin n_err++; $display("FAIL single_rw: got %h want 05", bus.rf_rw); end
    n_cmp++; if (bus.rf_pw !== 32'h14) begin n_err++; $display("FAIL single_pw: got %h want 00000014", bus.rf_pw); end
    n_cmp++; if (bus.write_count !== 16'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", bus.write_count); end
    step();
    n_cmp++; if (bus.rf_enable !== 1'b0) begin n_err++; $display("FAIL single_one_cycle: got %b want 0", bus.rf_enable); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.write_count !== 16'd1) begin n_err++; $display("FAIL single_count_hold: got %0d want 1", bus.write_count); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'hA;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = 32'hB;
    step();
    idle_inputs();
    #1;
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL tie_ready1_low: got %b want 0", bus.req1_ready); end
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL tie_ready0_high: got %b want 1", bus.req0_ready); end
    step();
    n_cmp++; if ({bus.rf_enable, bus.rf_rw, bus.rf_pw} !== {1'b1, 5'd3, 32'hA}) begin
      n_err++; $display("FAIL tie_first: got en=%b rw=%h pw=%h want en=1 rw=03 pw=0000000a", bus.rf_enable, bus.rf_rw, bus.rf_pw);
    end
    n_cmp++; if (bus.req1_ready !== 1'b1) begin n_err++; $display("FAIL tie_ready1_back: got %b want 1", bus.req1_ready); end
    step();
    n_cmp++; if ({bus.rf_enable, bus.rf_rw, bus.rf_pw} !== {1'b1, 5'd7, 32'hB}) begin
      n_err++; $display("FAIL tie_second: got en=%b rw=%h pw=%h want en=1 rw=07 pw=0000000b", bus.rf_enable, bus.rf_rw, bus.rf_pw);
    end
    step();
    n_cmp++; if (bus.rf_enable !== 1'b0) begin n_err++; $display("FAIL tie_done: got %b want 0", bus.rf_enable); end
    n_cmp++; if (bus.write_count !== 16'd2) begin n_err++; $display("FAIL tie_count: got %0d want 2", bus.write_count); end
  endtask

  task automatic test_same_addr();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd0; bus.req0_data = 32'h11;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'h22;
    step();
    idle_inputs();
    repeat (3) step();
    n_cmp++; if (obs_q.size() !== 2) begin n_err++; $display("FAIL same_addr_count: got %0d want 2", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[0] !== {5'd0, 32'h11}) begin n_err++; $display("FAIL same_addr_first: got %h want %h", obs_q[0], {5'd0, 32'h11}); end
      n_cmp++; if (obs_q[1] !== {5'd0, 32'h22}) begin n_err++; $display("FAIL same_addr_last: got %h want %h", obs_q[1], {5'd0, 32'h22}); end
    end
  endtask

  task automatic test_stream_both();
    int idx0 = 0;
    int idx1 = 0;
    logic [ADDR_W+DATA_W-1:0] exp_w;
    do_reset();
    for (int cyc = 0; cyc < 60 && (idx0 < 8 || idx1 < 8); cyc++) begin
      bus.req0_valid = (idx0 < 8); bus.req0_addr = 5'(idx0);      bus.req0_data = 32'h100 + 32'(idx0);
      bus.req1_valid = (idx1 < 8); bus.req1_addr = 5'(16 + idx1); bus.req1_data = 32'h200 + 32'(idx1);
      #1;
      if (bus.req0_valid && bus.req0_ready) idx0++;
      if (bus.req1_valid && bus.req1_ready) idx1++;
      step();
    end
    idle_inputs();
    repeat (4) step();
    n_cmp++; if (idx0 !== 8) begin n_err++; $display("FAIL stream_accepts0: got %0d want 8", idx0); end
    n_cmp++; if (idx1 !== 8) begin n_err++; $display("FAIL stream_accepts1: got %0d want 8", idx1); end
    n_cmp++; if (obs_q.size() !== 16) begin n_err++; $display("FAIL stream_writes: got %0d want 16", obs_q.size()); end
    else begin
      for (int j = 0; j < 16; j++) begin
        if (j % 2 == 0) exp_w = {5'(j / 2), 32'h100 + 32'(j / 2)};
        else            exp_w = {5'(16 + j / 2), 32'h200 + 32'(j / 2)};
        n_cmp++; if (obs_q[j] !== exp_w) begin n_err++; $display("FAIL stream_order[%0d]: got %h want %h", j, obs_q[j], exp_w); end
      end
    end
    n_cmp++; if (bus.write_count !== 16'd16) begin n_err++; $display("FAIL stream_count: got %0d want 16", bus.write_count); end
  endtask

  task automatic test_stream_single();
    do_reset();
    for (int i = 1; i <= 31; i++) begin
      bus.req1_valid = 1'b1; bus.req1_addr = 5'(i); bus.req1_data = 32'h14 + 32'(i);
      #1;
      n_cmp++; if (bus.req1_ready !== 1'b1) begin n_err++; $display("FAIL single_stream_ready[%0d]: got %b want 1", i, bus.req1_ready); end
      if (i >= 3) begin
        n_cmp++; if ({bus.rf_enable, bus.rf_rw} !== {1'b1, 5'(i - 2)}) begin
          n_err++; $display("FAIL single_stream_b2b[%0d]: got en=%b rw=%h want en=1 rw=%h", i, bus.rf_enable, bus.rf_rw, 5'(i - 2));
        end
      end
      step();
    end
    idle_inputs();
    repeat (3) step();
    n_cmp++; if (obs_q.size() !== 31) begin n_err++; $display("FAIL single_stream_writes: got %0d want 31", obs_q.size()); end
    else begin
      for (int j = 0; j < 31; j++) begin
        n_cmp++; if (obs_q[j] !== {5'(j + 1), 32'h15 + 32'(j)}) begin
          n_err++; $display("FAIL single_stream_data[%0d]: got %h want %h", j, obs_q[j], {5'(j + 1), 32'h15 + 32'(j)});
        end
      end
    end
    n_cmp++; if (bus.write_count !== 16'd31) begin n_err++; $display("FAIL single_stream_count: got %0d want 31", bus.write_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd9;  bus.req0_data = 32'h99;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd10; bus.req1_data = 32'hAA;
    step();
    idle_inputs();
    reset = 1'b1;
    #1;
    n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin n_err++; $display("FAIL mid_reset_readies: got %b want 00", {bus.req0_ready, bus.req1_ready}); end
    step();
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.rf_enable !== 1'b0) begin n_err++; $display("FAIL mid_reset_enable: got %b want 0", bus.rf_enable); end
    n_cmp++; if (bus.write_count !== 16'd0) begin n_err++; $display("FAIL mid_reset_count: got %0d want 0", bus.write_count); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin n_err++; $display("FAIL mid_reset_ready_after: got %b want 11", {bus.req0_ready, bus.req1_ready}); end
    step();
    n_cmp++; if (bus.rf_enable !== 1'b0) begin n_err++; $display("FAIL mid_reset_no_issue: got %b want 0", bus.rf_enable); end
    n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL mid_reset_discard: got %0d writes want 0", obs_q.size()); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd2; bus.req0_data = 32'h5A5A;
    repeat (65535) step();
    idle_inputs();
    repeat (3) step();
    n_cmp++; if (bus.write_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffff", bus.write_count); end
    bus.req0_valid = 1'b1;
    step();
    idle_inputs();
    step();
    n_cmp++; if (bus.rf_enable !== 1'b1) begin n_err++; $display("FAIL wrap_enable: got %b want 1", bus.rf_enable); end
    n_cmp++; if (bus.write_count !== 16'h0000) begin n_err++; $display("FAIL wrap_count: got %h want 0000", bus.write_count); end
    obs_q.delete();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_simultaneous();
    test_same_addr();
    test_stream_both();
    test_stream_single();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
